// File: rtl/mp_adder_pkg.sv
// Shared definitions for the sequential multi-precision adder:
// FSM state encodings and the fixed CLA word width.
package mp_adder_pkg;

  localparam int CLA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_32bits.sv
// 32-bit carry-lookahead adder stage: s = a + b + ci, co = carry out of bit 31.
// Purely combinational; one instance is time-shared by mp_adder_seq.
module cla_32bits
  import mp_adder_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 ci,
  output logic [CLA_WIDTH-1:0] s,
  output logic                 co
);

  logic [CLA_WIDTH-1:0] gen;
  logic [CLA_WIDTH-1:0] prop;

  assign gen  = a & b;
  assign prop = a ^ b;

  // NOTE: the carry is a local variable assigned with '=' inside always_comb, so
  // each bit sees the value computed by the previous iteration, and every output
  // is written on every pass, so no latch can be inferred.
  always_comb begin
    logic carry;
    carry = ci;
    s     = '0;
    for (int i = 0; i < CLA_WIDTH; i++) begin
      s[i]  = prop[i] ^ carry;
      carry = gen[i] | (prop[i] & carry);
    end
    co = carry;
  end

endmodule

// File: rtl/mp_adder_seq.sv
// Sequential multi-precision adder: one 32-bit word per cycle through a single
// cla_32bits, carry chained through a register. Define MP_ADDER_OVF_EN for the ovf port.
module mp_adder_seq
  import mp_adder_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] in_a,
  input  logic [WORDS*WIDTH-1:0] in_b,
  input  logic                   in_ci,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] sum,
  output logic                   co
`ifdef MP_ADDER_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int OP_W  = WORDS * WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]  sum_q, sum_d;
  logic             co_q, co_d;

  logic [WIDTH-1:0] cla_a, cla_b, cla_s;
  logic             cla_co;
  logic             last_word;

  assign cla_a     = a_q[idx_q*WIDTH +: WIDTH];
  assign cla_b     = b_q[idx_q*WIDTH +: WIDTH];
  assign last_word = (idx_q == IDX_LAST);

  cla_32bits u_cla (
    .a  (cla_a),
    .b  (cla_b),
    .ci (carry_q),
    .s  (cla_s),
    .co (cla_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_ci;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*WIDTH +: WIDTH] = cla_s;
        carry_d = cla_co;
        if (last_word) begin
          co_d    = cla_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: control and result registers use non-blocking '<=' and an async reset;
  // the operand registers stay out of the reset because they are always reloaded
  // on accept before anything reads them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

`ifdef MP_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // During the last RUN cycle the CLA operands are the MSWs, so their top bits are the signs.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ST_RUN && last_word)
      ovf_d = (cla_a[WIDTH-1] == cla_b[WIDTH-1]) && (cla_s[WIDTH-1] != cla_a[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign co        = co_q;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq (WORDS=4): directed corner cases plus
// randomized operands and output stalls, checked against a 129-bit arithmetic model.
module tb_mp_adder_seq;

  localparam int WORDS = 4;
  localparam int OP_W  = WORDS * 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a, in_b;
  logic            in_ci;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            co;
`ifdef MP_ADDER_OVF_EN
  logic            ovf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  mp_adder_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
`ifdef MP_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one operation, optionally stall the result for `stall` cycles while
  // poking in_valid with junk, and compare against plain wide arithmetic.
  task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input logic ci, input int stall, input bit full_checks);
    logic [OP_W:0]   golden;
    logic [OP_W+1:0] sgn;
    logic            exp_ovf;
    int              edges;
    golden  = {1'b0, a} + {1'b0, b} + {{OP_W{1'b0}}, ci};
    sgn     = {{2{a[OP_W-1]}}, a} + {{2{b[OP_W-1]}}, b} + {{(OP_W+1){1'b0}}, ci};
    exp_ovf = (sgn[OP_W] != sgn[OP_W-1]);

    @(negedge clk);
    if (full_checks) check("in_ready_idle", OP_W'(in_ready), OP_W'(1));
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_ci     = ci;
    out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    in_a     = rand_op();
    in_b     = rand_op();
    in_ci    = $urandom_range(0, 1);

    while (edges < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      edges++;
    end
    check("out_valid_seen", OP_W'(out_valid), OP_W'(1));
    check("latency", OP_W'(edges), OP_W'(WORDS + 1));
    check("sum", sum, golden[OP_W-1:0]);
    check("co", OP_W'(co), OP_W'(golden[OP_W]));
`ifdef MP_ADDER_OVF_EN
    check("ovf", OP_W'(ovf), OP_W'(exp_ovf));
`else
    if (exp_ovf) n_checks += 0;
`endif

    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_a     = rand_op();
      in_b     = rand_op();
      in_ci    = $urandom_range(0, 1);
      @(negedge clk);
      if (full_checks || s == stall - 1) begin
        check("stall_valid", OP_W'(out_valid), OP_W'(1));
        check("stall_ready", OP_W'(in_ready), OP_W'(0));
        check("stall_sum", sum, golden[OP_W-1:0]);
        check("stall_co", OP_W'(co), OP_W'(golden[OP_W]));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("released_valid", OP_W'(out_valid), OP_W'(0));
    if (full_checks) begin
      check("released_ready", OP_W'(in_ready), OP_W'(1));
      check("released_sum", sum, golden[OP_W-1:0]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_ci     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", OP_W'(in_ready), OP_W'(1));
    check("rst_out_valid", OP_W'(out_valid), OP_W'(0));
    check("rst_sum", sum, '0);
    check("rst_co", OP_W'(co), OP_W'(0));
`ifdef MP_ADDER_OVF_EN
    check("rst_ovf", OP_W'(ovf), OP_W'(0));
`endif
    rst = 1'b0;

    // Carry out of word 0 into word 1
    run_op(128'hFFFF_FFFF, 128'd1, 1'b0, 0, 1'b1);
    // Carry rippling through every word
    run_op({OP_W{1'b1}}, '0, 1'b1, 0, 1'b1);
    // Long output stall with ignored in_valid pulses
    run_op(rand_op(), rand_op(), 1'b1, 10, 1'b1);

    // Async reset in RUN with idx==2
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = {OP_W{1'b1}};
    in_b     = {OP_W{1'b1}};
    in_ci    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_valid", OP_W'(out_valid), OP_W'(0));
    check("midrun_rst_sum", sum, '0);
    check("midrun_rst_co", OP_W'(co), OP_W'(0));
    check("midrun_rst_ready", OP_W'(in_ready), OP_W'(1));
    @(negedge clk);
    rst = 1'b0;
    run_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
           1'b1, 2, 1'b1);

`ifdef MP_ADDER_OVF_EN
    run_op({1'b0, {(OP_W-1){1'b1}}}, 128'd1, 1'b0, 0, 1'b1);
    run_op({1'b1, {(OP_W-1){1'b0}}}, {OP_W{1'b1}}, 1'b0, 0, 1'b1);
    run_op(128'd5, 128'd7, 1'b0, 0, 1'b1);
`endif

    for (int i = 0; i < 2000; i++) begin
      logic [OP_W-1:0] ra, rb;
      int sel;
      sel = $urandom_range(0, 7);
      ra  = rand_op();
      rb  = rand_op();
      if (sel == 0) rb = ~ra;
      if (sel == 1) ra = {OP_W{1'b1}};
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fails);
    $finish;
  end

endmodule
